rgb_pwm_gen: RTL and testbench
==============================

// Module: rgb_pwm_gen
// PURPOSE
//  Source side of the SB_RGBA_DRV interface: generates the three RGBxPWM drive signals from
//  per-channel 8-bit duty values. Sits between the control logic (which delivers colour
//  updates over a valid/ready handshake) and the RGB primitive's RGB0PWM/RGB1PWM/RGB2PWM pins.
//  Updates take effect only at PWM period boundaries, so outputs never glitch mid-period.
// PARAMETERS
//  PWM_BITS  8   width of duty values and of the PWM period counter (period = 2^PWM_BITS steps)
//  PRESCALE  16  hw_clk cycles per PWM step; legal range >= 1
// PORTS
//  hw_clk        in   1         sole clock; all logic on posedge
//  rst_n         in   1         asynchronous active-low reset
//  cfg_valid     in   1         colour update offered
//  cfg_ready     out  1         block can accept an update
//  cfg_red       in   PWM_BITS  red duty   (feeds RGB0PWM)
//  cfg_green     in   PWM_BITS  green duty (feeds RGB1PWM)
//  cfg_blue      in   PWM_BITS  blue duty  (feeds RGB2PWM)
//  pwm_red       out  1         registered PWM output, red
//  pwm_green     out  1         registered PWM output, green
//  pwm_blue      out  1         registered PWM output, blue
//  period_start  out  1         one-cycle pulse at the start of each PWM period
// BEHAVIOUR
//  - Reset: pre_cnt=0, step_cnt=0, active/target duties=0, pwm_*=0, period_start=0, cfg_ready=1.
//  - Prescaler pre_cnt counts 0..PRESCALE-1; tick=1 when pre_cnt==PRESCALE-1, then wraps to 0.
//    With PRESCALE=1, tick=1 every cycle.
//  - step_cnt advances by 1 per tick and wraps 2^PWM_BITS-1 -> 0 (natural modulo).
//    Boundary: tick && step_cnt==max. period_start is registered; it is 1 in the cycle after
//    the boundary, when step_cnt==0.
//  - pwm_x is registered: pwm_x <= (step_cnt < active_x), one cycle behind the counter.
//    Duty 0 -> constantly 0. Duty 2^N-1 -> high for 2^N-1 of 2^N steps, never constantly 1.
//  - Handshake: transfer when cfg_valid && cfg_ready; all three cfg_* are captured into target_*.
//    cfg_ready drops in the following cycle and stays low while an update is pending.
//    cfg_* may change freely while cfg_valid=0.
//  - Apply: at a boundary with an update pending, active_* <= target_* and cfg_ready returns
//    to 1 in the next cycle. The new duties govern the period that begins at step_cnt==0.
//  - Simultaneous transfer and boundary in the same cycle: the transfer is NOT applied at that
//    boundary (target is loaded at the end of the cycle); it applies at the next boundary,
//    one full period later.
//  - Reset asserted mid-period: immediate return to reset values. Any pending update is lost
//    and the outputs go low asynchronously.
// CONFIGURATION
//  RGB_PWM_FADE_EN defined:
//    - At each boundary, every active_x that differs from target_x moves by exactly 1 toward it.
//    - The update stays pending, with cfg_ready=0, until all three active_x equal target_x.
//    - cfg_ready rises the cycle after the boundary at which the last channel matches.
//    - A transfer whose values equal the current active duties completes at the next boundary.
//  RGB_PWM_FADE_EN undefined:
//    - Active duties jump to target in one boundary, as described under BEHAVIOUR.
//    - No fade logic is synthesised.
// TESTING  (PWM_BITS=8, PRESCALE=2 -> period 512 cycles)
//  1 Reset, no transfer -> pwm_*=0, cfg_ready=1, period_start pulses every 512 cycles.
//  2 Transfer r=128,g=0,b=255 -> after the next boundary:
//      pwm_red high 256 of 512 cycles; pwm_green never high;
//      pwm_blue high 510 of 512 cycles (low for exactly 2).
//  3 Transfer in the exact boundary cycle -> old duty held for one more full period;
//    new duty appears after the following boundary; cfg_ready stays low throughout.
//  4 Hold cfg_valid=1 with new values while cfg_ready=0 -> no capture.
//    Second transfer completes the cycle cfg_ready returns to 1.
//  5 Assert rst_n=0 mid-period with an update pending -> all outputs 0 immediately,
//    cfg_ready=1 after release, old pending value never appears.
//  6 FADE_EN: active r=0, transfer r=3 -> red duty 1,2,3 over three successive periods;
//    cfg_ready=1 one cycle after the third boundary.

Source files
------------

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM source for the SB_RGBA_DRV RGBxPWM pins. Duty updates arrive over a
// valid/ready handshake and are applied only at period boundaries. Optional macro: RGB_PWM_FADE_EN.
module rgb_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic                hw_clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PWM_BITS-1:0] cfg_red,
    input  logic [PWM_BITS-1:0] cfg_green,
    input  logic [PWM_BITS-1:0] cfg_blue,
    output logic                pwm_red,
    output logic                pwm_green,
    output logic                pwm_blue,
    output logic                period_start
);

    // Handshake: a transfer occurs in any cycle with cfg_valid && cfg_ready. cfg_ready is low
    // from the cycle after a transfer until the cycle after the boundary that completes it.
    localparam int                 PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] STEP_MAX = '1;

    logic [PRE_W-1:0]    r_pre_cnt;
    logic [PWM_BITS-1:0] r_step_cnt;
    logic [PWM_BITS-1:0] r_active_red;
    logic [PWM_BITS-1:0] r_active_green;
    logic [PWM_BITS-1:0] r_active_blue;
    logic [PWM_BITS-1:0] r_target_red;
    logic [PWM_BITS-1:0] r_target_green;
    logic [PWM_BITS-1:0] r_target_blue;
    logic                r_cfg_ready;
    logic                r_pwm_red;
    logic                r_pwm_green;
    logic                r_pwm_blue;
    logic                r_period_start;

    logic                w_tick;
    logic                w_boundary;
    logic                w_xfer;
    logic                w_apply;
    logic [PWM_BITS-1:0] w_next_red;
    logic [PWM_BITS-1:0] w_next_green;
    logic [PWM_BITS-1:0] w_next_blue;
    logic                w_done;

    assign w_tick     = (r_pre_cnt == PRE_MAX);
    assign w_boundary = w_tick && (r_step_cnt == STEP_MAX);
    assign w_xfer     = cfg_valid && r_cfg_ready;
    // A pending update is exactly the state where cfg_ready is low.
    assign w_apply    = w_boundary && !r_cfg_ready;

`ifdef RGB_PWM_FADE_EN
    function automatic logic [PWM_BITS-1:0] f_step_toward(
        input logic [PWM_BITS-1:0] a,
        input logic [PWM_BITS-1:0] t
    );
        if (a < t)
            f_step_toward = a + 1'b1;
        else if (a > t)
            f_step_toward = a - 1'b1;
        else
            f_step_toward = a;
    endfunction

    assign w_next_red   = f_step_toward(r_active_red,   r_target_red);
    assign w_next_green = f_step_toward(r_active_green, r_target_green);
    assign w_next_blue  = f_step_toward(r_active_blue,  r_target_blue);
    assign w_done       = (w_next_red   == r_target_red)   &&
                          (w_next_green == r_target_green) &&
                          (w_next_blue  == r_target_blue);
`else
    assign w_next_red   = r_target_red;
    assign w_next_green = r_target_green;
    assign w_next_blue  = r_target_blue;
    assign w_done       = 1'b1;
`endif

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt      <= '0;
            r_step_cnt     <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pre_cnt  <= '0;
                r_step_cnt <= r_step_cnt + 1'b1;
            end else begin
                r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
            end
            r_period_start <= w_boundary;
        end
    end

    // Transfer and apply never coincide: a transfer needs cfg_ready high, apply needs it low.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_red   <= '0;
            r_active_green <= '0;
            r_active_blue  <= '0;
            r_target_red   <= '0;
            r_target_green <= '0;
            r_target_blue  <= '0;
            r_cfg_ready    <= 1'b1;
        end else begin
            if (w_apply) begin
                r_active_red   <= w_next_red;
                r_active_green <= w_next_green;
                r_active_blue  <= w_next_blue;
                if (w_done)
                    r_cfg_ready <= 1'b1;
            end
            if (w_xfer) begin
                r_target_red   <= cfg_red;
                r_target_green <= cfg_green;
                r_target_blue  <= cfg_blue;
                r_cfg_ready    <= 1'b0;
            end
        end
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_red   <= 1'b0;
            r_pwm_green <= 1'b0;
            r_pwm_blue  <= 1'b0;
        end else begin
            r_pwm_red   <= (r_step_cnt < r_active_red);
            r_pwm_green <= (r_step_cnt < r_active_green);
            r_pwm_blue  <= (r_step_cnt < r_active_blue);
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign pwm_red      = r_pwm_red;
    assign pwm_green    = r_pwm_green;
    assign pwm_blue     = r_pwm_blue;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen (PWM_BITS=8, PRESCALE=2, 512-cycle period) against a
// time-based reference model; the fade scenario runs only when RGB_PWM_FADE_EN is defined.
module tb_rgb_pwm_gen;

    localparam int PERIOD = 512;

    logic       hw_clk = 1'b0;
    logic       rst_n  = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_red = '0;
    logic [7:0] cfg_green = '0;
    logic [7:0] cfg_blue = '0;
    logic       pwm_red;
    logic       pwm_green;
    logic       pwm_blue;
    logic       period_start;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: m_c is the cycle index since reset release; a boundary is cycle 511 mod 512.
    int       m_c;
    int       m_act[3];
    int       m_tgt[3];
    bit       m_rdy;
    bit       e_pwm[3];
    bit       e_ps;
    int       hi[3];
    int       n_ps;
    int       n_rdy;

    rgb_pwm_gen #(.PWM_BITS(8), .PRESCALE(2)) dut (
        .hw_clk      (hw_clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_red     (cfg_red),
        .cfg_green   (cfg_green),
        .cfg_blue    (cfg_blue),
        .pwm_red     (pwm_red),
        .pwm_green   (pwm_green),
        .pwm_blue    (pwm_blue),
        .period_start(period_start)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) hi[i] = 0;
        n_ps  = 0;
        n_rdy = 0;
    endtask

    task automatic model_reset();
        m_c   = 0;
        m_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_tgt[i] = 0;
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then check outputs #1 later.
    task automatic cycle();
        int  cfg[3];
        int  step;
        bit  boundary;
        bit  rdy_now;
        bit  done;
        @(posedge hw_clk);
        cfg[0]   = int'(cfg_red);
        cfg[1]   = int'(cfg_green);
        cfg[2]   = int'(cfg_blue);
        step     = (m_c % PERIOD) / 2;
        boundary = ((m_c % PERIOD) == PERIOD - 1);
        rdy_now  = m_rdy;
        for (int i = 0; i < 3; i++) e_pwm[i] = (step < m_act[i]);
        e_ps = boundary;
        if (boundary && !rdy_now) begin
`ifdef RGB_PWM_FADE_EN
            done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (m_act[i] < m_tgt[i]) m_act[i] = m_act[i] + 1;
                else if (m_act[i] > m_tgt[i]) m_act[i] = m_act[i] - 1;
                if (m_act[i] != m_tgt[i]) done = 1'b0;
            end
`else
            done = 1'b1;
            for (int i = 0; i < 3; i++) m_act[i] = m_tgt[i];
`endif
            if (done) m_rdy = 1'b1;
        end
        if (cfg_valid && rdy_now) begin
            for (int i = 0; i < 3; i++) m_tgt[i] = cfg[i];
            m_rdy = 1'b0;
        end
        m_c++;
        #1;
        chk("pwm_red",      int'(pwm_red),      int'(e_pwm[0]));
        chk("pwm_green",    int'(pwm_green),    int'(e_pwm[1]));
        chk("pwm_blue",     int'(pwm_blue),     int'(e_pwm[2]));
        chk("period_start", int'(period_start), int'(e_ps));
        chk("cfg_ready",    int'(cfg_ready),    int'(m_rdy));
        hi[0] += int'(pwm_red);
        hi[1] += int'(pwm_green);
        hi[2] += int'(pwm_blue);
        n_ps  += int'(period_start);
        n_rdy += int'(cfg_ready);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (!cfg_valid) begin
                cfg_red   = 8'($urandom_range(0, 255));
                cfg_green = 8'($urandom_range(0, 255));
                cfg_blue  = 8'($urandom_range(0, 255));
            end
            cycle();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pwm_red",   int'(pwm_red),      0);
        chk("rst_pwm_green", int'(pwm_green),    0);
        chk("rst_pwm_blue",  int'(pwm_blue),     0);
        chk("rst_ps",        int'(period_start), 0);
        chk("rst_ready",     int'(cfg_ready),    1);
        repeat (3) @(posedge hw_clk);
        @(negedge hw_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input int r, input int g, input int b);
        cfg_valid = 1'b1;
        cfg_red   = 8'(r);
        cfg_green = 8'(g);
        cfg_blue  = 8'(b);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ps();
        bit seen = 1'b0;
        for (int i = 0; i < PERIOD + 16 && !seen; i++) begin
            cycle();
            seen = period_start;
        end
        chk("wait_period_start", int'(seen), 1);
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();

        // 1: idle after reset
        clear_counts();
        run(1100);
        chk("t1_ps_count", n_ps, 2);
        chk("t1_red_hi", hi[0], 0);
        chk("t1_blue_hi", hi[2], 0);

        // 2: basic transfer, full-period duty counts
        run(37);
        send(128, 0, 255);
        wait_ps();
        clear_counts();
        run(PERIOD);
        chk("t2_red_hi", hi[0], 256);
        chk("t2_green_hi", hi[1], 0);
        chk("t2_blue_hi", hi[2], 510);

        // 3: transfer in the boundary cycle waits one full period
        while ((m_c % PERIOD) != PERIOD - 1) run(1);
        send(40, 100, 7);
        clear_counts();
        run(PERIOD - 1);
        chk("t3_old_red_hi", hi[0], 256);
        chk("t3_ready_low", n_rdy, 0);
        run(1);
        chk("t3_ready_back", int'(cfg_ready), 1);
        clear_counts();
        run(PERIOD);
        chk("t3_new_red_hi", hi[0], 80);
        chk("t3_new_green_hi", hi[1], 200);
        chk("t3_new_blue_hi", hi[2], 14);

        // 4: valid held while not ready, second transfer when ready returns
        run(100);
        send(10, 20, 30);
        cfg_valid = 1'b1;
        cfg_red   = 8'd200;
        cfg_green = 8'd5;
        cfg_blue  = 8'd128;
        begin
            bit back = 1'b0;
            for (int i = 0; i < PERIOD + 16 && !back; i++) begin
                cycle();
                back = cfg_ready;
            end
            chk("t4_ready_returned", int'(back), 1);
        end
        clear_counts();
        cycle();
        cfg_valid = 1'b0;
        run(PERIOD - 1);
        chk("t4_a_red_hi", hi[0], 20);
        chk("t4_a_green_hi", hi[1], 40);
        chk("t4_a_blue_hi", hi[2], 60);
        clear_counts();
        run(PERIOD);
        chk("t4_b_red_hi", hi[0], 400);
        chk("t4_b_green_hi", hi[1], 10);
        chk("t4_b_blue_hi", hi[2], 256);

        // 5: reset mid-period with an update pending
        send(250, 250, 250);
        run(20);
        chk("t5_red_high_before_rst", int'(pwm_red), 1);
        chk("t5_pending", int'(cfg_ready), 0);
        apply_reset();
        clear_counts();
        run(1100);
        chk("t5_red_hi", hi[0], 0);
        chk("t5_green_hi", hi[1], 0);
        chk("t5_ready_cnt", n_rdy, 1100);

        // random transfers at random times
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(0, 700));
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        run(1100);

`ifdef RGB_PWM_FADE_EN
        // 6: fade red 0 -> 3
        apply_reset();
        run(50);
        send(3, 0, 0);
        wait_ps();
        clear_counts();
        run(PERIOD);
        chk("t6_red_hi_1", hi[0], 2);
        chk("t6_ready_low_1", n_rdy, 0);
        clear_counts();
        run(PERIOD);
        chk("t6_red_hi_2", hi[0], 4);
        chk("t6_ready_after_3rd", int'(cfg_ready), 1);
        chk("t6_ready_cnt_2", n_rdy, 1);
        clear_counts();
        run(PERIOD);
        chk("t6_red_hi_3", hi[0], 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
